// File: rtl/event_latch_arbiter_pkg.sv
// Shared types and sizing helpers for the event latch arbiter.
// Imported by the top and by the round-robin sub-block.
package event_latch_arbiter_pkg;

  typedef enum logic {
    IDLE,
    OFFER
  } state_t;

  localparam int NUM_EVT_MIN = 2;
  localparam int NUM_EVT_MAX = 16;

  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic bit num_evt_ok(input int n);
    return (n >= NUM_EVT_MIN) && (n <= NUM_EVT_MAX);
  endfunction

endpackage

// File: rtl/event_latch_arbiter_rr.sv
// Combinational round-robin picker: first request at or above ptr,
// wrapping from N-1 back to 0.
module rr_arbiter
  import event_latch_arbiter_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = id_width(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           any
);

  logic [IDW:0]   sum;
  logic [IDW-1:0] idx;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(N)) begin
        sum = sum - (IDW+1)'(N);
      end
      idx = sum[IDW-1:0];
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end

endmodule

// File: rtl/event_latch_arbiter.sv
// Latches synchronized rising edges into sticky pending bits and
// offers them one at a time downstream under round-robin arbitration.
module event_latch_arbiter
  import event_latch_arbiter_pkg::*;
#(
  parameter  int NUM_EVT     = 4,
  parameter  int SYNC_STAGES = 2,
  localparam int IDW         = id_width(NUM_EVT)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_EVT-1:0] evt_in,
  input  logic [NUM_EVT-1:0] evt_mask,
  output logic               evt_valid,
  output logic [IDW-1:0]     evt_id,
  input  logic               evt_ready,
  output logic [NUM_EVT-1:0] pending,
  output logic [NUM_EVT-1:0] ovf,
  input  logic [NUM_EVT-1:0] ovf_clr
);

  if (!num_evt_ok(NUM_EVT) || SYNC_STAGES < 2) begin : g_param_err
    $error("event_latch_arbiter: NUM_EVT 2..16, SYNC_STAGES >= 2");
  end

  logic [NUM_EVT-1:0] sync_out;
  logic [NUM_EVT-1:0] prev;
  logic [NUM_EVT-1:0] rise;

  for (genvar i = 0; i < NUM_EVT; i++) begin : g_sync
    logic [SYNC_STAGES-1:0] chain;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        chain <= '0;
      end else begin
        chain <= {chain[SYNC_STAGES-2:0], evt_in[i]};
      end
    end
    assign sync_out[i] = chain[SYNC_STAGES-1];
  end

  assign rise = sync_out & ~prev;

  state_t             state;
  state_t             state_n;
  logic               do_grant;
  logic [NUM_EVT-1:0] req;
  logic [NUM_EVT-1:0] gnt;
  logic [NUM_EVT-1:0] grant;
  logic [IDW-1:0]     gnt_id;
  logic [IDW-1:0]     ptr;
  logic [IDW-1:0]     ptr_n;
  logic               any;

  assign req = pending & evt_mask;

  rr_arbiter #(
    .N   (NUM_EVT),
    .IDW (IDW)
  ) u_rr (
    .req    (req),
    .ptr    (ptr),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .any    (any)
  );

  // A handshake frees the output register in the same cycle.
  always_comb begin
    state_n  = state;
    do_grant = 1'b0;
    unique case (state)
      IDLE: begin
        if (any) begin
          do_grant = 1'b1;
          state_n  = OFFER;
        end
      end
      OFFER: begin
        if (evt_ready) begin
          if (any) begin
            do_grant = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
    endcase
  end

  assign grant = {NUM_EVT{do_grant}} & gnt;

  assign ptr_n = (gnt_id == IDW'(NUM_EVT - 1)) ? '0
               : gnt_id + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      evt_id  <= '0;
      ptr     <= '0;
      prev    <= '0;
      pending <= '0;
      ovf     <= '0;
    end else begin
      state   <= state_n;
      prev    <= sync_out;
      pending <= (pending & ~grant) | rise;
      ovf     <= (ovf & ~ovf_clr) | (rise & pending & ~grant);
      if (do_grant) begin
        evt_id <= gnt_id;
        ptr    <= ptr_n;
      end
    end
  end

  assign evt_valid = (state == OFFER);

endmodule

// File: tb/tb_event_latch_arbiter.sv
// Bench for event_latch_arbiter: vector table, directed corner
// sequences and a randomized run against a reference model.
module tb_event_latch_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] evt_in;
  logic [N-1:0] evt_mask;
  logic         evt_ready;
  logic [N-1:0] ovf_clr;
  logic         evt_valid;
  logic [1:0]   evt_id;
  logic [N-1:0] pending;
  logic [N-1:0] ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  event_latch_arbiter #(
    .NUM_EVT     (N),
    .SYNC_STAGES (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .evt_in    (evt_in),
    .evt_mask  (evt_mask),
    .evt_valid (evt_valid),
    .evt_id    (evt_id),
    .evt_ready (evt_ready),
    .pending   (pending),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic cyc(input logic [N-1:0] e, input logic [N-1:0] m,
                     input logic r, input logic [N-1:0] c);
    evt_in    = e;
    evt_mask  = m;
    evt_ready = r;
    ovf_clr   = c;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [N-1:0] e, input logic [N-1:0] m,
                       input logic r);
    cyc(e, m, r, '0);
    cyc(e, m, r, '0);
    cyc('0, m, r, '0);
    cyc('0, m, r, '0);
    cyc('0, m, r, '0);
  endtask

  typedef struct {
    logic [N-1:0] e;
    logic [N-1:0] m;
    logic         v;
    logic [1:0]   id;
    logic [N-1:0] p;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic [N-1:0] e, input logic [N-1:0] m,
                              input logic v, input logic [1:0] id,
                              input logic [N-1:0] p);
    vec_t t;
    t.e  = e;
    t.m  = m;
    t.v  = v;
    t.id = id;
    t.p  = p;
    tbl.push_back(t);
  endfunction

  // Reference model state (state after the most recent clock edge)
  logic [N-1:0] m_pend, m_ovf, h1, h2, h3;
  logic         m_valid;
  int           m_id, m_ptr;

  task automatic model_reset();
    m_pend  = '0;
    m_ovf   = '0;
    h1      = '0;
    h2      = '0;
    h3      = '0;
    m_valid = 1'b0;
    m_id    = 0;
    m_ptr   = 0;
  endtask

  // One clock edge of the arbiter, in terms of events and slots.
  task automatic model_step(input logic [N-1:0] e, input logic [N-1:0] m,
                            input logic r, input logic [N-1:0] c);
    logic [N-1:0] rise;
    logic [N-1:0] g;
    bit found;
    int idx;
    rise = h2 & ~h3;
    h3 = h2;
    h2 = h1;
    h1 = e;
    g = '0;
    if (!m_valid || r) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (!found && m_pend[idx] && m[idx]) begin
          found  = 1;
          g[idx] = 1'b1;
          m_id   = idx;
        end
      end
      if (found) m_ptr = (m_id + 1) % N;
      m_valid = found;
    end
    for (int i = 0; i < N; i++) begin
      if (rise[i] && m_pend[i] && !g[i]) m_ovf[i] = 1'b1;
      else if (c[i]) m_ovf[i] = 1'b0;
      if (g[i]) m_pend[i] = 1'b0;
      if (rise[i]) m_pend[i] = 1'b1;
    end
  endtask

  initial begin
    int cnt;
    logic [1:0] last_id;
    logic [N-1:0] e, m, c;
    logic r;

    reset     = 1'b1;
    evt_in    = '0;
    evt_mask  = '0;
    evt_ready = 1'b0;
    ovf_clr   = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst valid", 32'(evt_valid), 0);
    chk("rst id", 32'(evt_id), 0);
    chk("rst pending", 32'(pending), 0);
    chk("rst ovf", 32'(ovf), 0);

    // Bursts on 0,1,3 twice, then single edge on 2, then masked edge on 2
    add(4'hB, 4'hF, 0, 0, 4'h0);
    add(4'hB, 4'hF, 0, 0, 4'h0);
    add(4'hB, 4'hF, 0, 0, 4'hB);
    add(4'h0, 4'hF, 1, 0, 4'hA);
    add(4'h0, 4'hF, 1, 1, 4'h8);
    add(4'h0, 4'hF, 1, 3, 4'h0);
    add(4'h0, 4'hF, 0, 3, 4'h0);
    add(4'hB, 4'hF, 0, 3, 4'h0);
    add(4'hB, 4'hF, 0, 3, 4'h0);
    add(4'hB, 4'hF, 0, 3, 4'hB);
    add(4'h0, 4'hF, 1, 0, 4'hA);
    add(4'h0, 4'hF, 1, 1, 4'h8);
    add(4'h0, 4'hF, 1, 3, 4'h0);
    add(4'h0, 4'hF, 0, 3, 4'h0);
    add(4'h4, 4'hF, 0, 3, 4'h0);
    add(4'h4, 4'hF, 0, 3, 4'h0);
    add(4'h4, 4'hF, 0, 3, 4'h4);
    add(4'h0, 4'hF, 1, 2, 4'h0);
    add(4'h0, 4'hF, 0, 2, 4'h0);
    add(4'h4, 4'hB, 0, 2, 4'h0);
    add(4'h4, 4'hB, 0, 2, 4'h0);
    add(4'h4, 4'hB, 0, 2, 4'h4);
    add(4'h0, 4'hB, 0, 2, 4'h4);
    add(4'h0, 4'hB, 0, 2, 4'h4);
    add(4'h0, 4'hF, 1, 2, 4'h0);
    add(4'h0, 4'hF, 0, 2, 4'h0);

    foreach (tbl[i]) begin
      cyc(tbl[i].e, tbl[i].m, 1'b1, '0);
      chk($sformatf("vec%0d valid", i), 32'(evt_valid), 32'(tbl[i].v));
      chk($sformatf("vec%0d id", i), 32'(evt_id), 32'(tbl[i].id));
      chk($sformatf("vec%0d pending", i), 32'(pending), 32'(tbl[i].p));
      chk($sformatf("vec%0d ovf", i), 32'(ovf), 0);
    end

    // Overflow on masked bit 1; clear colliding with a new edge
    pulse(4'h2, 4'hD, 1'b0);
    chk("ovf1 pend", 32'(pending), 32'h2);
    chk("ovf1 ovf", 32'(ovf), 0);
    chk("ovf1 valid", 32'(evt_valid), 0);
    pulse(4'h2, 4'hD, 1'b0);
    chk("ovf2 pend", 32'(pending), 32'h2);
    chk("ovf2 ovf", 32'(ovf), 32'h2);
    cyc(4'h2, 4'hD, 1'b0, '0);
    cyc(4'h2, 4'hD, 1'b0, '0);
    cyc(4'h0, 4'hD, 1'b0, 4'h2);
    chk("ovf set wins", 32'(ovf), 32'h2);
    cyc(4'h0, 4'hD, 1'b0, '0);
    cyc(4'h0, 4'hD, 1'b0, '0);
    cyc(4'h0, 4'hD, 1'b0, 4'h2);
    chk("ovf clr", 32'(ovf), 0);
    cyc(4'h0, 4'hF, 1'b1, '0);
    chk("ovf drain valid", 32'(evt_valid), 1);
    chk("ovf drain id", 32'(evt_id), 1);
    cyc(4'h0, 4'hF, 1'b1, '0);
    chk("ovf drain idle", 32'(evt_valid), 0);

    // Long stall on id 0 with a re-edge of the offered event
    pulse(4'h1, 4'hF, 1'b0);
    chk("stall valid", 32'(evt_valid), 1);
    chk("stall id", 32'(evt_id), 0);
    chk("stall pend", 32'(pending), 0);
    for (int i = 0; i < 10; i++) begin
      cyc((i < 2) ? 4'h1 : 4'h0, 4'hF, 1'b0, '0);
      chk($sformatf("stall hold%0d", i), 32'({evt_valid, evt_id}), 32'h4);
    end
    chk("stall repend", 32'(pending), 32'h1);
    chk("stall no ovf", 32'(ovf), 0);
    cyc(4'h0, 4'hF, 1'b1, '0);
    chk("b2b valid", 32'(evt_valid), 1);
    chk("b2b id", 32'(evt_id), 0);
    chk("b2b pend", 32'(pending), 0);
    cyc(4'h0, 4'hF, 1'b1, '0);
    chk("b2b idle", 32'(evt_valid), 0);

    // Reset in the middle of an offer with an input held high
    pulse(4'h8, 4'hF, 1'b0);
    pulse(4'h4, 4'hF, 1'b0);
    pulse(4'h4, 4'hF, 1'b0);
    cyc(4'h4, 4'hF, 1'b0, '0);
    chk("pre-rst valid", 32'({evt_valid, evt_id}), 32'h7);
    chk("pre-rst pend", 32'(pending), 32'h4);
    chk("pre-rst ovf", 32'(ovf), 32'h4);
    #2 reset = 1'b1;
    #1;
    chk("async rst valid", 32'(evt_valid), 0);
    chk("async rst pend", 32'(pending), 0);
    chk("async rst ovf", 32'(ovf), 0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    cnt = 0;
    last_id = '0;
    for (int i = 0; i < 12; i++) begin
      cyc(4'h4, 4'hF, 1'b1, '0);
      if (evt_valid) begin
        cnt++;
        last_id = evt_id;
      end
    end
    chk("post-rst count", 32'(cnt), 1);
    chk("post-rst id", 32'(last_id), 2);

    // Randomized run against the reference model
    evt_in    = '0;
    evt_mask  = '0;
    evt_ready = 1'b0;
    ovf_clr   = '0;
    reset     = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    e = '0;
    m = 4'hF;
    for (int i = 0; i < 2000; i++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 3) == 0) e[b] = ~e[b];
      end
      if (i % 16 == 0) begin
        m = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
      end
      r = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      model_step(e, m, r, c);
      cyc(e, m, r, c);
      chk($sformatf("rnd%0d valid", i), 32'(evt_valid), 32'(m_valid));
      chk($sformatf("rnd%0d id", i), 32'(evt_id), 32'(m_id));
      chk($sformatf("rnd%0d pending", i), 32'(pending), 32'(m_pend));
      chk($sformatf("rnd%0d ovf", i), 32'(ovf), 32'(m_ovf));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
